matrix_key_scanner: RTL and testbench
=====================================

# matrix_key_scanner

Input-side counterpart of the LED-matrix display driver: scans a passive key matrix over the same row/column wiring scheme. It drives one row line active-low at a time and samples the column lines. It debounces the result and reports one key code per press, with press/release pulses and a held level. It feeds the letter-selection and control logic that currently takes discrete buttons.

## Interface
- `ROWS`, default 4: number of row lines driven.
- `COLS`, default 4: number of column lines sampled.
- `DIV_W`, default 16: prescaler width; one scan tick every 2^DIV_W clk cycles.
- `DEB_N`, default 3: consecutive identical frames required to accept a press or a release (≥1).
- `KEY_W`: derived as $clog2(ROWS*COLS). Not user-set.
- `clk` input 1: single system clock; all logic is on its rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `COLUNA` input COLS: column lines; asynchronous, pulled up; low means a key in the driven row is closed.
- `LINHA` output ROWS: row drive, active-low; exactly one bit low outside reset.
- `key_code` output KEY_W: code of the accepted key, equal to row*COLS + col. Held until the next accepted press.
- `key_valid` output 1: one-clk pulse when a press is accepted.
- `key_held` output 1: high while the accepted key is considered down.
- `key_release` output 1: one-clk pulse when a release is accepted.

## Operation
- **Synchronizer:** `COLUNA` passes through 2 flops before any use; reset value is all ones.
- **Prescaler:** DIV_W-bit counter, free-running; `tick` is asserted when the counter equals all ones.
- **Row scan:** index `r` runs 0..ROWS-1 and `LINHA` = all ones with bit r cleared.
  - On `tick`: sample the synchronized columns for row r, then advance r, wrapping ROWS-1 -> 0.
  - Each row therefore settles for a full tick period before it is sampled.
- **Frame:** the ticks that sample rows 0..ROWS-1 form one frame. The frame is evaluated on the tick that samples row ROWS-1, using that tick's sample plus the rows stored earlier.
  - Candidate = lowest code among closed keys (lowest row first, then lowest column).
  - If no key is closed, the candidate is "none".
- **Debounce FSM,** states IDLE, DEB_PRESS, PRESSED, DEB_REL. It advances only at frame evaluation; `cnt` is the frame counter, `cand` the latched candidate.
  - **IDLE:** on a candidate, latch `cand`, set cnt=1 and go to DEB_PRESS. If DEB_N=1, accept immediately instead (go to PRESSED).
  - **DEB_PRESS:**
    - Candidate equals `cand`: cnt+1. When cnt reaches DEB_N, `key_code` <= cand, pulse `key_valid` and go to PRESSED.
    - Candidate is "none": go to IDLE.
    - Candidate is a different key: relatch `cand` and set cnt=1.
  - **PRESSED:** if the candidate is not `key_code` (none or another key), set cnt=1 and go to DEB_REL (with DEB_N=1, release immediately).
  - **DEB_REL:**
    - `key_code` is seen again: go back to PRESSED with no pulse.
    - Otherwise cnt+1. When cnt reaches DEB_N, pulse `key_release` and go to IDLE.
    - A new key can only be accepted starting from IDLE, i.e. from the frame after the release is accepted.
- `key_held` = 1 in PRESSED and DEB_REL.
- **Reset** (`rst_n` low at a clk edge), applied even mid-scan or mid-press:
  - `LINHA` = all ones, r=0, prescaler=0, FSM=IDLE, cnt=0, stored row samples = none.
  - `key_code`=0, `key_valid`=0, `key_held`=0, `key_release`=0.
  - A press in progress is discarded and no pulse is emitted.
- **Simultaneous events:** reset dominates `tick`. `key_valid` and `key_release` never assert in the same cycle.

## Timing
- All outputs are registered.
- `LINHA` drives row 0 (bit 0 low) in the first cycle after `rst_n` returns high. It changes one cycle after each `tick`.
- Tick period is 2^DIV_W clk cycles; frame period is ROWS·2^DIV_W.
- Input-to-sample latency: 2 clk (synchronizer) and at most 1 tick period.
- `key_valid` rises in the clk cycle after the evaluation tick of the DEB_N-th matching frame and lasts exactly 1 cycle.
  - Worst-case press latency: (DEB_N+1) frames + 2 clk.
- `key_held` rises in the same cycle as `key_valid`. It falls in the same cycle as `key_release`.
- Width rules:
  - Code = r*COLS + c, computed in KEY_W bits with no overflow, since the maximum is ROWS*COLS-1.
  - cnt is wide enough for DEB_N and saturates at DEB_N.

## Test plan
Settings: ROWS=4, COLS=4, DIV_W=4, DEB_N=3. One tick every 16 clk, one frame every 64 clk.
1. **Reset and scan:** `rst_n` low for 5 clk -> `LINHA`=4'b1111 and all key outputs 0. After release, `LINHA`=1110, then 1101 at clk ~17, then 1011, 0111, and wraps to 1110 every 64 clk.
2. **Clean press:** the bench closes row 2/col 1 (`COLUNA[1]` low while `LINHA[2]` low) for 8 frames. Required response:
   - `key_code`=9 and exactly one `key_valid` pulse, within 4 frames + 2 clk.
   - `key_held`=1 afterwards.
3. **Bounce:** the same key alternates closed/open every frame for 10 frames -> no `key_valid`, `key_held` stays 0.
4. **Multi-key:** keys 7 (row1/col3) and 12 (row3/col0) are held together -> `key_code`=7 with a single `key_valid`.
5. **Release:**
   - After test 2, a 1-frame open glitch -> no `key_release`, `key_held` stays 1.
   - A full release -> one `key_release` pulse after 3 open frames, and `key_held`=0 in that same cycle.
6. **Reset mid-press:** `rst_n` is asserted while in PRESSED with the key still held.
   - Outputs go to 0 on the next edge.
   - After release from reset, `key_code`=9 and `key_valid` recur only after a full 3-frame debounce.

Source files
------------

// File: rtl/matrix_key_scanner.sv
// Row-scanning keypad reader: drives one row low at a time, samples the columns,
// debounces whole frames and reports one key code per press with press/release pulses.
`timescale 1ns/1ps
module matrix_key_scanner #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int DIV_W = 16,
    parameter int DEB_N = 3,
    localparam int KEY_W = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [COLS-1:0]  COLUNA,
    output logic [ROWS-1:0]  LINHA,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_held,
    output logic             key_release
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = $clog2(DEB_N + 1);

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        PRESSED,
        DEB_REL
    } state_t;

    logic [COLS-1:0]            r_col_meta;
    logic [COLS-1:0]            r_col_sync;
    logic [DIV_W-1:0]           r_div;
    logic [RW-1:0]              r_row;
    logic [ROWS-1:0]            r_linha;
    logic [ROWS-1:0][COLS-1:0]  r_rows;

    state_t                     r_state;
    logic [CW-1:0]              r_cnt;
    logic [KEY_W-1:0]           r_cand;
    logic [KEY_W-1:0]           r_code;
    logic                       r_valid;
    logic                       r_held;
    logic                       r_release;

    logic                       w_tick;
    logic                       w_row_last;
    logic                       w_eval;
    logic [ROWS-1:0][COLS-1:0]  w_frame;
    logic                       w_cand_found;
    logic [KEY_W-1:0]           w_cand_code;
    logic                       w_same_key;
    logic [CW-1:0]              w_cnt_inc;
    logic                       w_cnt_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col_meta <= '1;
            r_col_sync <= '1;
        end else begin
            r_col_meta <= COLUNA;
            r_col_sync <= r_col_meta;
        end
    end

    assign w_tick     = (r_div == '1);
    assign w_row_last = (r_row == RW'(ROWS - 1));
    assign w_eval     = w_tick && w_row_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div   <= '0;
            r_row   <= '0;
            r_linha <= '1;
            r_rows  <= '0;
        end else begin
            r_div   <= r_div + 1'b1;
            r_linha <= ~(ROWS'(1) << r_row);
            if (w_tick) begin
                r_rows[r_row] <= ~r_col_sync;
                r_row         <= w_row_last ? '0 : r_row + 1'b1;
            end
        end
    end

    // The last row of a frame is taken straight from the synchronizer, not from storage.
    always_comb begin
        w_frame           = r_rows;
        w_frame[ROWS-1]   = ~r_col_sync;
    end

    always_comb begin
        w_cand_found = 1'b0;
        w_cand_code  = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                if (!w_cand_found && w_frame[r][c]) begin
                    w_cand_found = 1'b1;
                    w_cand_code  = KEY_W'(r * COLS + c);
                end
            end
        end
    end

    assign w_same_key = w_cand_found && (w_cand_code == r_code);
    assign w_cnt_inc  = (r_cnt >= CW'(DEB_N)) ? r_cnt : r_cnt + 1'b1;
    assign w_cnt_done = (w_cnt_inc == CW'(DEB_N));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_cand    <= '0;
            r_code    <= '0;
            r_valid   <= 1'b0;
            r_held    <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            r_release <= 1'b0;
            if (w_eval) begin
                case (r_state)
                    IDLE: begin
                        if (w_cand_found) begin
                            r_cand <= w_cand_code;
                            r_cnt  <= CW'(1);
                            if (DEB_N <= 1) begin
                                r_code  <= w_cand_code;
                                r_valid <= 1'b1;
                                r_held  <= 1'b1;
                                r_state <= PRESSED;
                            end else begin
                                r_state <= DEB_PRESS;
                            end
                        end
                    end
                    DEB_PRESS: begin
                        if (!w_cand_found) begin
                            r_cnt   <= '0;
                            r_state <= IDLE;
                        end else if (w_cand_code == r_cand) begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_done) begin
                                r_code  <= r_cand;
                                r_valid <= 1'b1;
                                r_held  <= 1'b1;
                                r_state <= PRESSED;
                            end
                        end else begin
                            r_cand <= w_cand_code;
                            r_cnt  <= CW'(1);
                        end
                    end
                    PRESSED: begin
                        if (!w_same_key) begin
                            r_cnt <= CW'(1);
                            if (DEB_N <= 1) begin
                                r_cnt     <= '0;
                                r_release <= 1'b1;
                                r_held    <= 1'b0;
                                r_state   <= IDLE;
                            end else begin
                                r_state <= DEB_REL;
                            end
                        end
                    end
                    DEB_REL: begin
                        if (w_same_key) begin
                            r_state <= PRESSED;
                        end else begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_done) begin
                                r_cnt     <= '0;
                                r_release <= 1'b1;
                                r_held    <= 1'b0;
                                r_state   <= IDLE;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign LINHA       = r_linha;
    assign key_code    = r_code;
    assign key_valid   = r_valid;
    assign key_held    = r_held;
    assign key_release = r_release;

endmodule

// File: tb/tb_matrix_key_scanner.sv
// Directed bench for matrix_key_scanner with a passive 4x4 key-matrix model.
`timescale 1ns/1ps
module tb_matrix_key_scanner;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int DIV_W = 4;
    localparam int DEB_N = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] COLUNA;
    logic [3:0] LINHA;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       key_release;

    logic [15:0] keys = '0;
    int errors = 0;
    int checks = 0;
    int valid_cnt = 0;
    int rel_cnt = 0;

    always #5 clk = ~clk;

    matrix_key_scanner #(
        .ROWS(ROWS),
        .COLS(COLS),
        .DIV_W(DIV_W),
        .DEB_N(DEB_N)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .COLUNA(COLUNA),
        .LINHA(LINHA),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_held(key_held),
        .key_release(key_release)
    );

    // A closed key shorts its row line onto its column line.
    always_comb begin
        COLUNA = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (LINHA[r] == 1'b0 && keys[r*4+c]) COLUNA[c] = 1'b0;
    end

    always @(negedge clk) begin
        if (key_valid) begin
            valid_cnt++;
            checks++;
            if (key_held !== 1'b1) begin
                errors++;
                $display("FAIL held_with_valid: key_held=%b required 1", key_held);
            end
        end
        if (key_release) begin
            rel_cnt++;
            checks++;
            if (key_held !== 1'b0) begin
                errors++;
                $display("FAIL held_with_release: key_held=%b required 0", key_held);
            end
        end
        if (key_valid && key_release) begin
            checks++;
            errors++;
            $display("FAIL valid_release_overlap: valid=%b release=%b required not both", key_valid, key_release);
        end
    end

    task automatic wait_row0;
        logic [3:0] prev;
        prev = LINHA;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if (LINHA == 4'b1110 && prev != 4'b1110) return;
            prev = LINHA;
        end
        $display("FAIL wait_row0: LINHA=%b required 1110 within 200 clk", LINHA);
        $fatal(1, "row scan stalled");
    endtask

    task automatic test_reset;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (LINHA !== 4'b1111) begin errors++; $display("FAIL reset_linha: got %b required 1111", LINHA); end
        checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL reset_code: got %0d required 0", key_code); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", key_valid); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held: got %b required 0", key_held); end
        checks++; if (key_release !== 1'b0) begin errors++; $display("FAIL reset_release: got %b required 0", key_release); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (LINHA !== 4'b1110) begin errors++; $display("FAIL scan_edge1: got %b required 1110", LINHA); end
        repeat (15) @(posedge clk);
        #1;
        checks++; if (LINHA !== 4'b1110) begin errors++; $display("FAIL scan_edge16: got %b required 1110", LINHA); end
        @(posedge clk); #1;
        checks++; if (LINHA !== 4'b1101) begin errors++; $display("FAIL scan_edge17: got %b required 1101", LINHA); end
        repeat (16) @(posedge clk);
        #1;
        checks++; if (LINHA !== 4'b1011) begin errors++; $display("FAIL scan_edge33: got %b required 1011", LINHA); end
        repeat (16) @(posedge clk);
        #1;
        checks++; if (LINHA !== 4'b0111) begin errors++; $display("FAIL scan_edge49: got %b required 0111", LINHA); end
        repeat (16) @(posedge clk);
        #1;
        checks++; if (LINHA !== 4'b1110) begin errors++; $display("FAIL scan_wrap: got %b required 1110", LINHA); end
    endtask

    task automatic test_press;
        int v0;
        int lat;
        wait_row0();
        v0 = valid_cnt;
        keys = 16'h0200;
        lat = 0;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            if (key_valid) begin lat = i; break; end
        end
        checks++; if (lat != 191) begin errors++; $display("FAIL press_latency: got %0d clk required 191", lat); end
        checks++; if (key_code !== 4'd9) begin errors++; $display("FAIL press_code: got %0d required 9", key_code); end
        checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL press_held: got %b required 1", key_held); end
        repeat (320) @(posedge clk);
        #1;
        checks++; if (valid_cnt - v0 != 1) begin errors++; $display("FAIL press_pulses: got %0d required 1", valid_cnt - v0); end
        checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL press_held_later: got %b required 1", key_held); end
    endtask

    task automatic test_glitch;
        int r0;
        int drops;
        r0 = rel_cnt;
        drops = 0;
        wait_row0();
        keys = 16'h0000;
        wait_row0();
        keys = 16'h0200;
        for (int i = 0; i < 192; i++) begin
            @(posedge clk); #1;
            if (!key_held) drops++;
        end
        checks++; if (rel_cnt != r0) begin errors++; $display("FAIL glitch_release: got %0d pulses required 0", rel_cnt - r0); end
        checks++; if (drops != 0) begin errors++; $display("FAIL glitch_held: held low %0d clk required 0", drops); end
        checks++; if (key_code !== 4'd9) begin errors++; $display("FAIL glitch_code: got %0d required 9", key_code); end
    endtask

    task automatic test_release;
        int r0;
        int lat;
        wait_row0();
        r0 = rel_cnt;
        keys = 16'h0000;
        lat = 0;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            if (key_release) begin lat = i; break; end
        end
        checks++; if (lat != 191) begin errors++; $display("FAIL release_latency: got %0d clk required 191", lat); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL release_held: got %b required 0", key_held); end
        repeat (4) @(posedge clk);
        #1;
        checks++; if (rel_cnt - r0 != 1) begin errors++; $display("FAIL release_pulses: got %0d required 1", rel_cnt - r0); end
    endtask

    task automatic test_bounce;
        int v0;
        int highs;
        v0 = valid_cnt;
        highs = 0;
        for (int f = 0; f < 10; f++) begin
            wait_row0();
            if (key_held) highs++;
            keys = (f % 2 == 0) ? 16'h0200 : 16'h0000;
        end
        wait_row0();
        if (key_held) highs++;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (valid_cnt != v0) begin errors++; $display("FAIL bounce_valid: got %0d pulses required 0", valid_cnt - v0); end
        checks++; if (highs != 0 || key_held !== 1'b0) begin errors++; $display("FAIL bounce_held: high at %0d frame starts, now %b, required 0", highs, key_held); end
    endtask

    task automatic test_multikey;
        int v0;
        int r0;
        int lat;
        wait_row0();
        v0 = valid_cnt;
        keys = 16'h1080;
        lat = 0;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            if (key_valid) begin lat = i; break; end
        end
        checks++; if (lat != 191) begin errors++; $display("FAIL multi_latency: got %0d clk required 191", lat); end
        checks++; if (key_code !== 4'd7) begin errors++; $display("FAIL multi_code: got %0d required 7", key_code); end
        repeat (128) @(posedge clk);
        #1;
        checks++; if (valid_cnt - v0 != 1) begin errors++; $display("FAIL multi_pulses: got %0d required 1", valid_cnt - v0); end
        r0 = rel_cnt;
        keys = 16'h0000;
        repeat (320) @(posedge clk);
        #1;
        checks++; if (rel_cnt - r0 != 1) begin errors++; $display("FAIL multi_release: got %0d pulses required 1", rel_cnt - r0); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL multi_held_after: got %b required 0", key_held); end
    endtask

    task automatic test_reset_mid_press;
        int v0;
        int r0;
        int lat;
        wait_row0();
        keys = 16'h0200;
        repeat (260) @(posedge clk);
        #1;
        checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL midrst_pre_held: got %b required 1", key_held); end
        @(negedge clk) rst_n = 1'b0;
        v0 = valid_cnt;
        r0 = rel_cnt;
        @(posedge clk); #1;
        checks++; if (LINHA !== 4'b1111) begin errors++; $display("FAIL midrst_linha: got %b required 1111", LINHA); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL midrst_held: got %b required 0", key_held); end
        checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL midrst_code: got %0d required 0", key_code); end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        lat = 0;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            if (key_valid) begin lat = i; break; end
        end
        checks++; if (lat != 192) begin errors++; $display("FAIL midrst_latency: got %0d clk required 192", lat); end
        checks++; if (key_code !== 4'd9) begin errors++; $display("FAIL midrst_code_after: got %0d required 9", key_code); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (valid_cnt - v0 != 1) begin errors++; $display("FAIL midrst_pulses: got %0d required 1", valid_cnt - v0); end
        checks++; if (rel_cnt != r0) begin errors++; $display("FAIL midrst_release: got %0d pulses required 0", rel_cnt - r0); end
        keys = 16'h0000;
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_release();
        test_bounce();
        test_multikey();
        test_reset_mid_press();
        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
